// File: rtl/ring_freq_meter.sv
// Gated frequency meter: counts rising edges of one selected oscillator
// input over a programmable window of clk cycles.
module ring_freq_meter #(
    parameter int CNT_W         = 16,
    parameter int GATE_MIN_LOG2 = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       osc_in,
    input  logic [1:0]       sel,
    input  logic [1:0]       gate_sel,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             ovf,
    output logic [CNT_W-1:0] result
);

    localparam int GW = GATE_MIN_LOG2 + 3;
    localparam logic [GW:0] ONE_G = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_sel_q;
    logic [1:0]       r_gsel_q;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_hist;
    logic [1:0]       r_arm;
    logic [GW-1:0]    r_gate;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_int;
    logic             r_done;
    logic             r_valid;
    logic             r_ovf;
    logic [CNT_W-1:0] r_result;

    logic             w_rise;
    logic             w_inc;
    logic             w_sat;
    logic [CNT_W-1:0] w_cnt_next;
    logic [GW:0]      w_gate_full;
    logic [GW-1:0]    w_gate_max;
    logic             w_arm_end;
    logic             w_gate_end;

    assign w_rise      = r_sync2 & ~r_hist;
    assign w_inc       = (r_state == S_COUNT) && w_rise;
    assign w_sat       = w_inc && (&r_cnt);
    assign w_cnt_next  = (w_inc && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    // G = 2^(min+gsel); wraps to all-ones in GW bits for the largest gate.
    assign w_gate_full = ONE_G << (GATE_MIN_LOG2 + int'(r_gsel_q));
    assign w_gate_max  = GW'(w_gate_full - ONE_G);
    assign w_arm_end   = (r_state == S_ARM) && (r_arm == 2'd2);
    assign w_gate_end  = (r_state == S_COUNT) && (r_gate == w_gate_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_ARM;
            S_ARM:   if (w_arm_end) w_next = S_COUNT;
            S_COUNT: if (w_gate_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_q   <= '0;
            r_gsel_q  <= '0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_hist    <= 1'b0;
            r_arm     <= '0;
            r_gate    <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_sync1 <= osc_in[r_sel_q];
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel_q   <= sel;
                        r_gsel_q  <= gate_sel;
                        r_cnt     <= '0;
                        r_ovf_int <= 1'b0;
                        r_valid   <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_arm     <= '0;
                    end
                end
                S_ARM: begin
                    r_arm  <= r_arm + 1'b1;
                    r_gate <= '0;
                end
                S_COUNT: begin
                    r_cnt     <= w_cnt_next;
                    r_ovf_int <= r_ovf_int | w_sat;
                    r_gate    <= r_gate + 1'b1;
                    // Publish on the edge entering DONE, last increment included.
                    if (w_gate_end) begin
                        r_result <= w_cnt_next;
                        r_ovf    <= r_ovf_int | w_sat;
                        r_valid  <= 1'b1;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign valid  = r_valid;
    assign ovf    = r_ovf;
    assign result = r_result;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed bench for ring_freq_meter: main instance with 16-bit count and a
// 3-bit count instance for saturation, both with 16-cycle minimum gate.
module tb_ring_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  osc_in;
    logic [1:0]  sel = '0;
    logic [1:0]  gate_sel = '0;
    logic        start = 1'b0;
    logic        busy, done, valid, ovf;
    logic [15:0] result;
    logic        busy_s, done_s, valid_s, ovf_s;
    logic [2:0]  result_s;

    logic t0 = 1'b0;
    logic t1 = 1'b0;
    logic o0_run = 1'b1;
    logic o2 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    initial begin
        #2;
        forever #20 t0 = ~t0;
    end
    initial begin
        #2;
        forever #40 t1 = ~t1;
    end
    assign osc_in = {1'b0, o2, t1, o0_run ? t0 : 1'b0};

    ring_freq_meter #(.CNT_W(16), .GATE_MIN_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .sel(sel),
        .gate_sel(gate_sel), .start(start), .busy(busy), .done(done),
        .valid(valid), .ovf(ovf), .result(result)
    );

    ring_freq_meter #(.CNT_W(3), .GATE_MIN_LOG2(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .sel(sel),
        .gate_sel(gate_sel), .start(start), .busy(busy_s), .done(done_s),
        .valid(valid_s), .ovf(ovf_s), .result(result_s)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start one measurement and follow it to done; called at a negedge.
    task automatic run_meas(input logic [1:0] s, input logic [1:0] g);
        int n;
        int gl;
        gl = (16 << g) + 4;
        sel = s;
        gate_sel = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sel = ~s;
        gate_sel = ~g;
        n = 1;
        chk("busy_rise", int'(busy), 1);
        chk("valid_clr", int'(valid), 0);
        while (!done && n < gl + 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_lat", n, gl);
        chk("valid_set", int'(valid), 1);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("busy_fall", int'(busy), 0);
    endtask

    initial begin
        int n;
        int nd;

        // Reset with inputs toggling
        repeat (4) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_result", int'(result), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_valid", int'(valid), 0);
        chk("post_rst_result", int'(result), 0);

        // Basic count: period 4, G=16
        run_meas(2'd0, 2'd0);
        chk("basic_result", int'(result), 4);
        chk("basic_ovf", int'(ovf), 0);

        // Mux step onto a static-high input is swallowed by ARM
        o2 = 1'b1;
        repeat (3) @(negedge clk);
        run_meas(2'd2, 2'd0);
        chk("sel2_result", int'(result), 0);

        // Period 8 on input 1 over G=128
        run_meas(2'd1, 2'd3);
        chk("sel1_result", int'(result), 16);

        // Saturation on the 3-bit instance, G=64
        run_meas(2'd0, 2'd2);
        chk("sat_result", int'(result_s), 7);
        chk("sat_ovf", int'(ovf_s), 1);
        chk("wide_result", int'(result), 16);
        chk("wide_ovf", int'(ovf), 0);

        // Static input clears the sticky overflow
        o0_run = 1'b0;
        repeat (5) @(negedge clk);
        run_meas(2'd0, 2'd2);
        chk("static_result_s", int'(result_s), 0);
        chk("static_ovf_s", int'(ovf_s), 0);
        chk("static_result", int'(result), 0);
        o0_run = 1'b1;
        repeat (5) @(negedge clk);

        // Start pulse during COUNT is ignored
        sel = 2'd0;
        gate_sel = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("ignored_start_dones", nd, 1);
        chk("ignored_start_busy", int'(busy), 0);
        chk("ignored_start_result", int'(result), 4);

        // Held start: back-to-back runs spaced G+5
        start = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held_first_done", int'(done), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) chk("held_valid_drop", int'(valid), 0);
        end while (!done && n < 200);
        start = 1'b0;
        chk("held_spacing", n, 21);
        chk("held_valid", int'(valid), 1);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("held_stop_dones", nd, 0);
        chk("held_stop_busy", int'(busy), 0);

        // Reset in the middle of COUNT
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_valid", int'(valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst_dones", nd, 0);
        chk("midrst_valid_after", int'(valid), 0);
        run_meas(2'd0, 2'd0);
        chk("after_rst_result", int'(result), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Gated frequency meter downstream of the ring-oscillator bank. It selects one of four free-running oscillator or divider outputs, synchronises it into the `clk` domain, and counts its rising edges over a programmable gate window of `clk` cycles. It latches the count as a readable result with valid, done and overflow flags. It lets firmware or the bench characterise each ring against the known system clock instead of relying on an external scope.

## Interface
Parameters:
- `CNT_W`, 16: width of edge counter and `result`.
- `GATE_MIN_LOG2`, 10: log2 of the shortest gate window in `clk` cycles.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `osc_in`  in  4  asynchronous oscillator or divider outputs to be measured.
- `sel`  in  2  index into `osc_in`; sampled only when `start` is accepted.
- `gate_sel`  in  2  gate length G = 2^(`GATE_MIN_LOG2` + `gate_sel`) cycles; sampled only when `start` is accepted.
- `start`  in  1  level, sampled each cycle; accepted only in IDLE.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when `result` updates.
- `valid`  out  1  `result` holds a completed measurement; cleared on accepted `start`.
- `ovf`  out  1  last measurement saturated.
- `result`  out  `CNT_W`  rising-edge count of the last completed window.

## Operation
Front end:
- `osc_in[sel_q]` is chosen by a mux on the latched select `sel_q`.
- The mux output passes through a 2-FF synchroniser plus one history flop.
- `rise` = sync & ~hist.

Input limit: the selected input must have high and low phases each ≥ 1.5 `clk` periods. Faster inputs undercount; this is not detected. Measure fast rings through their divided outputs.

FSM states, with transitions:
- IDLE: on `start`=1, latch `sel_q`←`sel` and `gsel_q`←`gate_sel`; clear the count, `valid`, and `ovf`; go to ARM.
- ARM: runs exactly 3 cycles. The synchroniser and history flush the mux switch. `rise` is ignored. Go to COUNT.
- COUNT: runs exactly G cycles. Each cycle with `rise`=1 increments the count, saturating at 2^`CNT_W`−1. An increment attempted at saturation sets the sticky `ovf_int`. After G cycles, go to DONE.
- DONE: runs 1 cycle. `result`←count (including any increment from the last COUNT cycle); `ovf`←`ovf_int`; `done`=1; `valid`←1. Go to IDLE.

Boundary and reset rules:
- `start` while `busy` is ignored (no queueing).
- `start` held high re-triggers on the first IDLE cycle, giving back-to-back measurements.
- `sel`/`gate_sel` changes outside acceptance have no effect.
- Async reset mid-operation forces IDLE. `busy`, `done`, `valid`, `ovf` and `result` all go to 0, the count clears, and the synchroniser flops clear. No partial result is ever published.
- The gate counter is wide enough for G = 2^(`GATE_MIN_LOG2`+3). It is compared against G−1 from the latched `gsel_q`.

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` accepted at edge t: `busy`=1 from t+1; ARM covers t+1..t+3; COUNT covers t+4..t+3+G.
- DONE occurs at t+4+G: `done`=1, and `result`/`valid`/`ovf` are updated on that same edge.
- `busy`=0 from t+5+G.
- Minimum period between accepted starts: G+5 cycles.
- Edge-to-count latency: 3 `clk` cycles (2 sync + history). An edge arriving within ~3 cycles before the window closes is counted in neither window. This is the accepted ±1 quantisation.
- `done` is never asserted on two consecutive cycles.

## Test plan
- Reset: assert `rst_n`=0 with `osc_in` toggling -> all outputs 0 and `busy`=0; after release they stay 0 until `start`.
- Basic count: `GATE_MIN_LOG2`=4, `gate_sel`=0 (G=16), `osc_in[0]` square with period 4 `clk` (2 high/2 low), `start` pulse at t -> `busy` at t+1; `done` pulse at t+20; `result`=4; `valid`=1; `ovf`=0.
- Selection and flush: `osc_in[2]` held high, `osc_in[0]` toggling, `sel`=2, `start` -> `result`=0 (the mux step edge is swallowed by ARM). Then `sel`=1 with `osc_in[1]` at period 8 and `gate_sel`=3 (G=128) -> `result`=16.
- Overflow: `CNT_W`=3, G=64, period-4 input -> `result`=7, `ovf`=1. A following run with a static input -> `ovf`=0, `result`=0.
- Start rules: `start` pulse during COUNT -> ignored, exactly one `done`. `start` held high -> `done` pulses spaced exactly G+5 cycles apart, and `valid` drops for each new run.
- Reset mid-COUNT: `rst_n` low for 2 cycles at t+10 -> `busy`=0, `result`=0, `valid`=0, no `done` pulse. A subsequent `start` measures normally (`result`=4 for the basic-count stimulus).
